// File: rtl/object_ram_arbiter_pkg.sv
// Shared definitions for the object RAM arbiter and the masters around it.
//
// Holds the master encoding used to steer the RAM mux, the lock state
// encoding, and the default address/data widths shared with the rope
// controllers and the stone-draw engine.
package object_ram_arbiter_pkg;

    localparam int DEF_ADDR_W       = 4;   // 16 objects
    localparam int DEF_DATA_W       = 32;  // one object word
    localparam int DEF_LOCK_TIMEOUT = 64;

    // Which master currently owns the RAM port
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        DRAW  = 2'd1,
        ROPE0 = 2'd2,
        ROPE1 = 2'd3
    } master_e;

    // Which rope, if any, holds the atomic lock
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_e;

    // One-hot lock holder as seen on lock_owner (bit n = rope n)
    function automatic logic [1:0] owner_onehot(lock_state_e s);
        logic [1:0] o;
        o = 2'b00;
        if (s == LOCK0) o = 2'b01;
        if (s == LOCK1) o = 2'b10;
        return o;
    endfunction

endpackage

// File: rtl/object_ram_arbiter_if.sv
// Bus bundle between the object RAM masters, the arbiter and the RAM macro.
//
// Master side: draw_* (read-only stone-draw engine), rope_* (two rope
// controllers, bit/suffix n = rope n), lock_owner/lock_err status.
// RAM side: ram_address/ram_data/ram_wren towards the macro, ram_q back,
// valid one cycle after the address.
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives grants and RAM pins)
//   master - the environment's view (drives requests and ram_q)
interface object_ram_arbiter_if
    import object_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic              draw_gnt;
    logic              draw_rvalid;

    logic [1:0]        rope_req;
    logic [1:0]        rope_we;
    logic [1:0]        rope_lock;
    logic [ADDR_W-1:0] rope_addr0;
    logic [ADDR_W-1:0] rope_addr1;
    logic [DATA_W-1:0] rope_wdata0;
    logic [DATA_W-1:0] rope_wdata1;
    logic [1:0]        rope_gnt;
    logic [1:0]        rope_rvalid;

    logic [1:0]        lock_owner;
    logic              lock_err;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  draw_req, draw_addr,
        input  rope_req, rope_we, rope_lock, rope_addr0, rope_addr1,
        input  rope_wdata0, rope_wdata1,
        input  ram_q,
        output draw_gnt, draw_rvalid, rope_gnt, rope_rvalid,
        output lock_owner, lock_err,
        output ram_address, ram_data, ram_wren
    );

    modport master (
        output draw_req, draw_addr,
        output rope_req, rope_we, rope_lock, rope_addr0, rope_addr1,
        output rope_wdata0, rope_wdata1,
        output ram_q,
        input  draw_gnt, draw_rvalid, rope_gnt, rope_rvalid,
        input  lock_owner, lock_err,
        input  ram_address, ram_data, ram_wren
    );

endinterface

// File: rtl/object_ram_arbiter_rr_picker2.sv
// Two-requester round-robin picker.
//
// Ports:
//   clock, reset - clock, async active-high reset (pointer clears to 0)
//   req[1:0]     - requests already filtered for eligibility
//   en           - picking allowed this cycle; when low gnt is 0 and the
//                  pointer holds
//   gnt[1:0]     - one-hot (or zero) grant
//   ptr          - current preferred requester
//
// After any grant the pointer moves to the other requester, so a lone
// requester also hands preference to its partner.
module rr_picker2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/object_ram_arbiter.sv
// Object RAM arbiter: shares the single-port object RAM between the
// read-only stone-draw engine and two read/write rope controllers.
//
// Ports:
//   clock, reset - system clock, async active-high reset
//   bus          - object_ram_arbiter_if.slave: master requests/grants,
//                  read-return valids, lock status and the RAM pins
// Parameters:
//   LOCK_TIMEOUT - cycles a rope lock may be held before forced release
//   ADDR_W/DATA_W - must match the interface instance
//
// Draw always wins; ropes share the rest round-robin. A rope may hold a
// lock across accesses to do an atomic read-modify-write; the other rope
// simply stalls meanwhile.
module object_ram_arbiter
    import object_ram_arbiter_pkg::*;
#(
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    object_ram_arbiter_if.slave  bus
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lock_err_q, lock_err_d;
    logic [2:0]        tag_q, tag_d;      // {rope1, rope0, draw} read issued
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren;

    logic [1:0]        eligible;
    logic [1:0]        rope_pick;
    logic              draw_gnt;
    logic              rr;
    logic              timeout;
    master_e           sel;

    // Grants are masked while reset is asserted so nothing reaches the RAM.
    assign draw_gnt = bus.draw_req && !reset;

    // A held lock shuts out the other rope; the holder keeps arbitrating
    // normally (including losing to draw).
    always_comb begin
        eligible = 2'b11;
        case (state_q)
            LOCK0:   eligible = 2'b01;
            LOCK1:   eligible = 2'b10;
            default: eligible = 2'b11;
        endcase
    end

    // Ropes only get the port when draw is not asking for it, so draw
    // cycles leave the round-robin pointer alone.
    rr_picker2 u_rr_picker2 (
        .clock (clock),
        .reset (reset),
        .req   (bus.rope_req & eligible),
        .en    (!bus.draw_req && !reset),
        .gnt   (rope_pick),
        .ptr   (rr)
    );

    always_comb begin
        sel = NONE;
        if (draw_gnt) begin
            sel = DRAW;
        end else if (rope_pick[0]) begin
            sel = ROPE0;
        end else if (rope_pick[1]) begin
            sel = ROPE1;
        end
    end

    // RAM mux: with no grant the address/data pins hold their last granted
    // values and the write enable stays low.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wren   = 1'b0;
        case (sel)
            DRAW: begin
                addr_d = bus.draw_addr;
            end
            ROPE0: begin
                addr_d = bus.rope_addr0;
                data_d = bus.rope_wdata0;
                wren   = bus.rope_we[0];
            end
            ROPE1: begin
                addr_d = bus.rope_addr1;
                data_d = bus.rope_wdata1;
                wren   = bus.rope_we[1];
            end
            default: ;
        endcase
    end

    // Lock FSM and timeout counter. Arbitration this cycle already used
    // state_q, so a forced release only affects the following cycle.
    always_comb begin
        timeout = (state_q != IDLE) && (cnt_q == CNT_LAST);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel == ROPE0 && bus.rope_lock[0]) begin
                    state_d = LOCK0;
                end else if (sel == ROPE1 && bus.rope_lock[1]) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sel == ROPE0 && !bus.rope_lock[0]) begin
                    state_d = IDLE;
                end
            end
            LOCK1: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sel == ROPE1 && !bus.rope_lock[1]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
        if (state_d == IDLE) begin
            cnt_d = '0;
        end
        // Registered so the pulse lands in the cycle the counter sits at
        // its last value, i.e. the release cycle.
        lock_err_d = (state_d != IDLE) && (cnt_d == CNT_LAST);
    end

    // Only reads leave a tag; it lines up with ram_q one cycle later.
    always_comb begin
        tag_d = {rope_pick[1] & ~bus.rope_we[1],
                 rope_pick[0] & ~bus.rope_we[0],
                 draw_gnt};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lock_err_q <= 1'b0;
            tag_q      <= 3'b000;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
            tag_q      <= tag_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.draw_gnt    = draw_gnt;
    assign bus.rope_gnt    = rope_pick;
    assign bus.draw_rvalid = tag_q[0];
    assign bus.rope_rvalid = tag_q[2:1];
    assign bus.lock_owner  = owner_onehot(state_q);
    assign bus.lock_err    = lock_err_q;
    assign bus.ram_address = addr_d;
    assign bus.ram_data    = data_d;
    assign bus.ram_wren    = wren;

endmodule

// File: tb/tb_object_ram_arbiter.sv
// Directed testbench for object_ram_arbiter with a behavioural 16x32 RAM.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_object_ram_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    object_ram_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    object_ram_arbiter #(.LOCK_TIMEOUT(64), .ADDR_W(4), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port RAM model with a backdoor write port for preloading
    logic [31:0] mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_addr = 4'd0;
    logic [31:0] bd_data = 32'd0;

    always @(posedge clock) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.ram_wren) begin
            mem[bus.ram_address] <= bus.ram_data;
        end
        bus.ram_q <= mem[bus.ram_address];
    end

    task automatic idle_inputs();
        bus.draw_req    = 1'b0;
        bus.draw_addr   = 4'd0;
        bus.rope_req    = 2'b00;
        bus.rope_we     = 2'b00;
        bus.rope_lock   = 2'b00;
        bus.rope_addr0  = 4'd0;
        bus.rope_addr1  = 4'd0;
        bus.rope_wdata0 = 32'd0;
        bus.rope_wdata1 = 32'd0;
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.draw_req = 1'b1;
        bus.rope_req = 2'b11;
        @(negedge clock); #1;
        checks++; if (bus.draw_gnt !== 1'b0 || bus.rope_gnt !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_gnt draw=%b rope=%b expected 0/00", bus.draw_gnt, bus.rope_gnt); end
        checks++; if (bus.draw_rvalid !== 1'b0 || bus.rope_rvalid !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_rvalid draw=%b rope=%b expected 0/00", bus.draw_rvalid, bus.rope_rvalid); end
        checks++; if (bus.lock_owner !== 2'b00 || bus.lock_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_lock owner=%b err=%b expected 00/0", bus.lock_owner, bus.lock_err); end
        checks++; if (bus.ram_wren !== 1'b0 || bus.ram_address !== 4'd0 || bus.ram_data !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_ram wren=%b addr=%h data=%h expected 0/0/0", bus.ram_wren, bus.ram_address, bus.ram_data); end
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_draw_read();
        preload(4'd5, 32'hA5A5_0003);
        @(negedge clock);
        bus.draw_req = 1'b1; bus.draw_addr = 4'd5; #1;
        checks++; if (bus.draw_gnt !== 1'b1 || bus.rope_gnt !== 2'b00) begin
            errors++; $display("[TB] FAIL draw_gnt draw=%b rope=%b expected 1/00", bus.draw_gnt, bus.rope_gnt); end
        checks++; if (bus.ram_address !== 4'd5 || bus.ram_wren !== 1'b0) begin
            errors++; $display("[TB] FAIL draw_ram addr=%h wren=%b expected 5/0", bus.ram_address, bus.ram_wren); end
        @(negedge clock);
        bus.draw_req = 1'b0; #1;
        checks++; if (bus.draw_rvalid !== 1'b1 || bus.ram_q !== 32'hA5A5_0003) begin
            errors++; $display("[TB] FAIL draw_return rvalid=%b q=%h expected 1/a5a50003", bus.draw_rvalid, bus.ram_q); end
        checks++; if (bus.draw_gnt !== 1'b0 || bus.ram_address !== 4'd5 || bus.rope_rvalid !== 2'b00) begin
            errors++; $display("[TB] FAIL draw_idle_hold gnt=%b addr=%h rope_rvalid=%b expected 0/5/00", bus.draw_gnt, bus.ram_address, bus.rope_rvalid); end
    endtask

    task automatic test_contention();
        @(negedge clock);
        bus.draw_req = 1'b1; bus.draw_addr = 4'd0;
        bus.rope_req = 2'b11; bus.rope_addr0 = 4'd1; bus.rope_addr1 = 4'd2; #1;
        checks++; if (bus.draw_gnt !== 1'b1 || bus.rope_gnt !== 2'b00) begin
            errors++; $display("[TB] FAIL contend_draw draw=%b rope=%b expected 1/00", bus.draw_gnt, bus.rope_gnt); end
        @(negedge clock);
        bus.draw_req = 1'b0; #1;
        checks++; if (bus.rope_gnt !== 2'b01 || bus.ram_address !== 4'd1 || bus.draw_rvalid !== 1'b1) begin
            errors++; $display("[TB] FAIL contend_rope0 gnt=%b addr=%h draw_rvalid=%b expected 01/1/1", bus.rope_gnt, bus.ram_address, bus.draw_rvalid); end
        @(negedge clock);
        bus.rope_req = 2'b10; #1;
        checks++; if (bus.rope_gnt !== 2'b10 || bus.ram_address !== 4'd2 || bus.rope_rvalid !== 2'b01) begin
            errors++; $display("[TB] FAIL contend_rope1 gnt=%b addr=%h rvalid=%b expected 10/2/01", bus.rope_gnt, bus.ram_address, bus.rope_rvalid); end
        @(negedge clock);
        bus.rope_req = 2'b11; #1;
        checks++; if (bus.rope_gnt !== 2'b01 || bus.rope_rvalid !== 2'b10) begin
            errors++; $display("[TB] FAIL contend_rr_back_to_0 gnt=%b rvalid=%b expected 01/10", bus.rope_gnt, bus.rope_rvalid); end
        @(negedge clock);
        bus.rope_req = 2'b10; #1;
        checks++; if (bus.rope_gnt !== 2'b10) begin
            errors++; $display("[TB] FAIL contend_rope1_again gnt=%b expected 10", bus.rope_gnt); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_atomic_claim();
        preload(4'd3, 32'h0000_0011);
        @(negedge clock);
        bus.rope_req = 2'b11; bus.rope_addr0 = 4'd3; bus.rope_addr1 = 4'd3;
        bus.rope_we = 2'b00; bus.rope_lock = 2'b01; #1;
        checks++; if (bus.rope_gnt !== 2'b01 || bus.lock_owner !== 2'b00) begin
            errors++; $display("[TB] FAIL claim_read gnt=%b owner=%b expected 01/00", bus.rope_gnt, bus.lock_owner); end
        @(negedge clock);
        bus.rope_req = 2'b10; #1;
        checks++; if (bus.rope_gnt !== 2'b00 || bus.lock_owner !== 2'b01) begin
            errors++; $display("[TB] FAIL claim_stall gnt=%b owner=%b expected 00/01", bus.rope_gnt, bus.lock_owner); end
        checks++; if (bus.rope_rvalid !== 2'b01 || bus.ram_q !== 32'h0000_0011) begin
            errors++; $display("[TB] FAIL claim_read_return rvalid=%b q=%h expected 01/00000011", bus.rope_rvalid, bus.ram_q); end
        @(negedge clock);
        bus.rope_req = 2'b11; bus.rope_we = 2'b01; bus.rope_wdata0 = 32'hCAFE_0001; bus.rope_lock = 2'b00; #1;
        checks++; if (bus.rope_gnt !== 2'b01 || bus.ram_wren !== 1'b1 || bus.lock_owner !== 2'b01) begin
            errors++; $display("[TB] FAIL claim_write gnt=%b wren=%b owner=%b expected 01/1/01", bus.rope_gnt, bus.ram_wren, bus.lock_owner); end
        @(negedge clock);
        bus.rope_req = 2'b10; bus.rope_we = 2'b00; #1;
        checks++; if (bus.rope_gnt !== 2'b10 || bus.lock_owner !== 2'b00 || bus.rope_rvalid !== 2'b00) begin
            errors++; $display("[TB] FAIL claim_release gnt=%b owner=%b rvalid=%b expected 10/00/00", bus.rope_gnt, bus.lock_owner, bus.rope_rvalid); end
        @(negedge clock);
        bus.rope_req = 2'b00; #1;
        checks++; if (bus.rope_rvalid !== 2'b10 || bus.ram_q !== 32'hCAFE_0001) begin
            errors++; $display("[TB] FAIL claim_rope1_sees_write rvalid=%b q=%h expected 10/cafe0001", bus.rope_rvalid, bus.ram_q); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        @(negedge clock);
        bus.rope_req = 2'b10; bus.rope_lock = 2'b10; bus.rope_addr1 = 4'd7; #1;
        checks++; if (bus.rope_gnt !== 2'b10) begin
            errors++; $display("[TB] FAIL timeout_lock_gnt gnt=%b expected 10", bus.rope_gnt); end
        @(negedge clock);
        bus.rope_req = 2'b01; bus.rope_lock = 2'b00; bus.rope_addr0 = 4'd8;
        for (int k = 1; k <= 63; k++) begin
            if (k > 1) @(negedge clock);
            #1;
            checks++; if ({bus.rope_gnt, bus.lock_err, bus.lock_owner} !== 5'b00_0_10) begin
                errors++; $display("[TB] FAIL timeout_held cycle=%0d gnt=%b err=%b owner=%b expected 00/0/10", k, bus.rope_gnt, bus.lock_err, bus.lock_owner); end
        end
        @(negedge clock); #1;
        checks++; if (bus.lock_err !== 1'b1 || bus.rope_gnt !== 2'b00 || bus.lock_owner !== 2'b10) begin
            errors++; $display("[TB] FAIL timeout_pulse err=%b gnt=%b owner=%b expected 1/00/10", bus.lock_err, bus.rope_gnt, bus.lock_owner); end
        @(negedge clock); #1;
        checks++; if (bus.rope_gnt !== 2'b01 || bus.lock_err !== 1'b0 || bus.lock_owner !== 2'b00) begin
            errors++; $display("[TB] FAIL timeout_after err=%b gnt=%b owner=%b expected 0/01/00", bus.lock_err, bus.rope_gnt, bus.lock_owner); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_write_then_read();
        @(negedge clock);
        bus.rope_req = 2'b01; bus.rope_we = 2'b01; bus.rope_addr0 = 4'd15; bus.rope_wdata0 = 32'h1234_5678; #1;
        checks++; if (bus.rope_gnt !== 2'b01 || bus.ram_wren !== 1'b1 || bus.ram_address !== 4'd15 || bus.ram_data !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL wr_write gnt=%b wren=%b addr=%h data=%h expected 01/1/f/12345678", bus.rope_gnt, bus.ram_wren, bus.ram_address, bus.ram_data); end
        @(negedge clock);
        idle_inputs();
        bus.draw_req = 1'b1; bus.draw_addr = 4'd15; #1;
        checks++; if (bus.draw_gnt !== 1'b1 || bus.rope_rvalid !== 2'b00) begin
            errors++; $display("[TB] FAIL wr_draw_gnt gnt=%b rope_rvalid=%b expected 1/00", bus.draw_gnt, bus.rope_rvalid); end
        @(negedge clock);
        bus.draw_req = 1'b0; #1;
        checks++; if (bus.draw_rvalid !== 1'b1 || bus.ram_q !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL wr_readback rvalid=%b q=%h expected 1/12345678", bus.draw_rvalid, bus.ram_q); end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        bus.rope_req = 2'b01; bus.rope_lock = 2'b01; bus.rope_addr0 = 4'd15; #1;
        checks++; if (bus.rope_gnt !== 2'b01) begin
            errors++; $display("[TB] FAIL areset_lock_gnt gnt=%b expected 01", bus.rope_gnt); end
        @(negedge clock); #1;
        checks++; if (bus.lock_owner !== 2'b01 || bus.rope_gnt !== 2'b01 || bus.rope_rvalid !== 2'b01) begin
            errors++; $display("[TB] FAIL areset_locked owner=%b gnt=%b rvalid=%b expected 01/01/01", bus.lock_owner, bus.rope_gnt, bus.rope_rvalid); end
        #2;
        reset = 1'b1; #1;
        checks++; if (bus.rope_gnt !== 2'b00 || bus.lock_owner !== 2'b00 || bus.rope_rvalid !== 2'b00 || bus.draw_rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_immediate gnt=%b owner=%b rvalid=%b draw_rvalid=%b expected 00/00/00/0", bus.rope_gnt, bus.lock_owner, bus.rope_rvalid, bus.draw_rvalid); end
        checks++; if (bus.ram_wren !== 1'b0 || bus.ram_address !== 4'd0 || bus.ram_data !== 32'd0) begin
            errors++; $display("[TB] FAIL areset_ram wren=%b addr=%h data=%h expected 0/0/0", bus.ram_wren, bus.ram_address, bus.ram_data); end
        @(negedge clock);
        reset = 1'b0;
        idle_inputs(); #1;
        checks++; if (bus.rope_rvalid !== 2'b00 || bus.lock_owner !== 2'b00) begin
            errors++; $display("[TB] FAIL areset_no_rvalid rvalid=%b owner=%b expected 00/00", bus.rope_rvalid, bus.lock_owner); end
        @(negedge clock);
        bus.rope_req = 2'b11; bus.rope_addr0 = 4'd1; bus.rope_addr1 = 4'd2; #1;
        checks++; if (bus.rope_gnt !== 2'b01) begin
            errors++; $display("[TB] FAIL areset_rr_cleared gnt=%b expected 01", bus.rope_gnt); end
        @(negedge clock);
        bus.rope_req = 2'b10; #1;
        checks++; if (bus.rope_gnt !== 2'b10) begin
            errors++; $display("[TB] FAIL areset_idle_rope1 gnt=%b expected 10", bus.rope_gnt); end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_draw_read();
        test_contention();
        test_atomic_claim();
        test_timeout();
        test_write_then_read();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/object_ram_arbiter.md
# object_ram_arbiter

Arbitrates the single-port 16×32 object RAM between three masters: the stone-draw engine, which is read-only, and two rope controllers, which read and write (player 0 and player 1 in two-player mode). The draw engine has fixed top priority. The two ropes share the remaining slots round-robin. A rope may lock the RAM against the other rope for an atomic read-modify-write, such as claiming a stone. The block sits between the masters and the RAM macro and replaces per-rope address muxing.

## Interface
Parameters:
- LOCK_TIMEOUT, default 64: maximum cycles a rope lock may be held before forced release.
- ADDR_W, default 4: RAM address width (16 objects).
- DATA_W, default 32: object word width.

Ports (name, direction, width, meaning):
- clock, in, 1: system clock.
- reset, in, 1: one clock; reset is asynchronous and active-high.
- draw_req, in, 1: draw engine read request.
- draw_addr, in, ADDR_W: draw read address.
- draw_gnt, out, 1: draw request accepted this cycle.
- draw_rvalid, out, 1: ram_q belongs to draw this cycle.
- rope_req, in, 2: per-rope request; index 0 or 1.
- rope_we, in, 2: 1 for write, 0 for read.
- rope_lock, in, 2: hold the lock after this access.
- rope_addr0 / rope_addr1, in, ADDR_W each: rope addresses.
- rope_wdata0 / rope_wdata1, in, DATA_W each: rope write data.
- rope_gnt, out, 2: rope request accepted this cycle.
- rope_rvalid, out, 2: ram_q belongs to that rope this cycle.
- lock_owner, out, 2: one-hot current lock holder; 00 when unlocked.
- lock_err, out, 1: one-cycle pulse on lock timeout.
- ram_address, out, ADDR_W: to RAM.
- ram_data, out, DATA_W: to RAM.
- ram_wren, out, 1: to RAM.
- ram_q, in, DATA_W: from RAM, valid 1 cycle after address.

## Operation
- **Grants**
  - At most one grant per cycle.
  - Grants are combinational from the current cycle's requests and the registered state.
  - A requester holds req, address, we and wdata stable until it sees its grant.
- **Priority**
  - draw_req always wins.
  - Otherwise, eligible ropes are served round-robin using the 1-bit pointer rr. rr names the preferred rope.
  - After any rope grant, rr is set to the other rope.
  - rr is unchanged by draw grants and idle cycles.
- **Eligibility**
  - In IDLE, both ropes are eligible.
  - In LOCKn, only rope n is eligible. The other rope's request stalls, with no grant and no error.
- **Lock states:** IDLE, LOCK0, LOCK1.
  - IDLE → LOCKn when rope n is granted with rope_lock[n]=1.
  - LOCKn → IDLE when rope n is granted with rope_lock[n]=0. That access itself completes normally.
  - LOCKn → LOCKn when rope n is granted with rope_lock[n]=1. The timeout counter keeps running.
  - LOCKn → IDLE with lock_err pulsed when the lock counter reaches LOCK_TIMEOUT-1.
- **Lock counter**
  - Clears on lock entry.
  - Increments every cycle in LOCKn, including stalled and draw-granted cycles.
  - Saturates only through the forced release.
- **RAM port**
  - ram_address, ram_data and ram_wren are muxed from the granted master.
  - With no grant: ram_wren=0, and ram_address/ram_data hold their last granted values.
  - Draw is never a write.
- **Read return**
  - A 3-bit registered tag records which master received a read grant.
  - draw_rvalid / rope_rvalid[n] assert the following cycle, concurrent with valid ram_q.
  - Write grants produce no rvalid.

## Timing
- **Read latency:** grant in cycle N → rvalid and ram_q in cycle N+1. Throughput is one access per cycle.
- **Write:** data is committed at the end of the grant cycle. A read of the same address granted in cycle N+1 returns the new data in N+2.
- **Simultaneous requests**
  - draw + rope0 + rope1: draw is granted. Ropes retry next cycle; rr is unchanged.
  - rope0 + rope1 in IDLE: rope[rr] wins.
- **Forced release:** on the timeout cycle the state returns to IDLE immediately. A pending rope request in that same cycle is arbitrated against the pre-release state.
- **Reset (async)**
  - All gnt and rvalid are 0. With reset asserted, grants are forced 0 regardless of req.
  - State IDLE, lock_owner=00, rr=0, lock counter 0, lock_err 0.
  - ram_wren=0, ram_address=0, ram_data=0.
  - A read in flight at reset produces no rvalid.

## Structure
- Shared package holds:
  - master encoding: NONE, DRAW, ROPE0, ROPE1;
  - lock state encoding;
  - ADDR_W / DATA_W defaults, common with the rope and draw modules.
- One natural sub-module, `rr_picker2`: two-requester round-robin with a pointer update enable.
- Everything else stays in the top: lock FSM, timeout counter, tag pipe, RAM mux.

## Test plan
- **Draw read:** draw_req=1, draw_addr=5, RAM[5]=0xA5A5_0003 → draw_gnt the same cycle; draw_rvalid=1 and ram_q=0xA5A5_0003 the next cycle.
- **Three-way contention for 3 cycles:** draw_req high 1 cycle, then both ropes with rr=0 → grant sequence draw, rope0, rope1. rr ends at 0.
- **Atomic claim**
  - Stimulus: rope0 reads addr 3 with lock=1, then writes addr 3 with lock=0; rope1 requests addr 3 throughout.
  - Response: rope1 is ungranted until rope0's write cycle has passed; lock_owner=01 between; rope1's read returns rope0's written value.
- **Timeout:** rope1 locks and then idles for LOCK_TIMEOUT cycles → lock_err pulses exactly once at cycle 64 after lock entry; a waiting rope0 is granted the following cycle.
- **Write-then-read:** rope0 writes 0x1234_5678 to addr 15, then draw reads addr 15 → 0x1234_5678 returned; no rvalid on the write.
- **Async reset mid-lock with a read in flight:** assert reset between clock edges → all outputs at reset values immediately; no rvalid after deassertion; state IDLE.
